// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the single-step / free-run clock controller.
// Holds the FSM state enum (whose values are also the state_dbg display
// codes), the default debounce/repeat periods and the timer sizing helper.
package step_ctrl_pkg;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
   localparam int unsigned DEF_REPEAT_CYCLES   = 25_000_000;
   localparam int unsigned STATE_W             = 3;

   // Encodings double as the hex debug display codes.
   typedef enum logic [STATE_W-1:0] {
      RUN        = 3'd0,
      IDLE       = 3'd1,
      DB_PRESS   = 3'd2,
      PULSE      = 3'd3,
      HELD       = 3'd4,
      DB_RELEASE = 3'd5
   } step_state_e;

   // Timer width large enough to reach (larger period - 1); at least 1 bit.
   function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/step_controller_counter.sv
// Debounce/repeat timer: synchronous clear, otherwise counts up and
// saturates at all-ones so it can never wrap.
// Ports: clk, rst (async active-low), clr_i (clear), cnt_o (count).
module step_controller_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Clear wins; otherwise increment until saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/step_controller.sv
// Single-step / free-run controller for the CPU advance strobe.
// Debounces a pushbutton, emits one step_en per accepted press with
// auto-repeat while held, or asserts step_en continuously in free-run.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   step_mode  raw switch, 1 = single-step, 0 = free-run
//   key_n      raw pushbutton, 0 = pressed
//   step_en    registered advance strobe
//   step_count single-step pulses issued, modulo 256
//   state_dbg  current FSM state code for the debug display
module step_controller
   import step_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step_mode,
   input  logic       key_n,
   output logic       step_en,
   output logic [7:0] step_count,
   output logic [2:0] state_dbg
);

   localparam int unsigned TMR_W = timer_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
   localparam logic [TMR_W-1:0] DB_LAST  = TMR_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] RPT_LAST = TMR_W'(REPEAT_CYCLES - 1);

   logic        mode_meta_q, mode_sync_q;
   logic        key_meta_q, key_sync_q;
   step_state_e state_q, state_d;
   logic        step_en_q, step_en_d;
   logic [7:0]  count_q, count_d;
   logic [TMR_W-1:0] timer;
   logic        timer_clr_c;
   logic        pressed_c;

   // 2-flop synchronizers; reset to "single-step, key released".
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_meta_q <= 1'b1;
         mode_sync_q <= 1'b1;
         key_meta_q  <= 1'b1;
         key_sync_q  <= 1'b1;
      end else begin
         mode_meta_q <= step_mode;
         mode_sync_q <= mode_meta_q;
         key_meta_q  <= key_n;
         key_sync_q  <= key_meta_q;
      end
   end

   assign pressed_c = ~key_sync_q;

   // Timer restarts on every state change.
   assign timer_clr_c = (state_d != state_q);

   step_controller_counter #(
      .W (TMR_W)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clr_i (timer_clr_c),
      .cnt_o (timer)
   );

   // Next-state and registered-output values.
   always_comb begin
      state_d   = state_q;
      step_en_d = 1'b0;
      count_d   = count_q;

      case (state_q)
         RUN:        state_d = IDLE;
         IDLE:       if (pressed_c) state_d = DB_PRESS;
         DB_PRESS: begin
            if (!pressed_c)             state_d = IDLE;
            else if (timer == DB_LAST)  state_d = PULSE;
         end
         PULSE:      state_d = HELD;
         HELD: begin
            if (!pressed_c)             state_d = DB_RELEASE;
            else if (timer == RPT_LAST) state_d = PULSE;
         end
         DB_RELEASE: begin
            if (pressed_c)              state_d = HELD;
            else if (timer == DB_LAST)  state_d = IDLE;
         end
         default:    state_d = IDLE;
      endcase

      // Free-run overrides all key activity.
      if (!mode_sync_q) begin
         state_d = RUN;
      end

      if (state_d == RUN || state_d == PULSE) begin
         step_en_d = 1'b1;
      end
      if (state_d == PULSE) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         step_en_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         step_en_q <= step_en_d;
         count_q   <= count_d;
      end
   end

   assign step_en    = step_en_q;
   assign step_count = count_q;
   assign state_dbg  = STATE_W'(state_q);

endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller: directed scenarios plus random key/mode
// segments, every cycle compared against a run-length reference model.
module tb_step_controller;

   localparam int unsigned D = 4;
   localparam int unsigned R = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       step_mode = 1'b1;
   logic       key_n = 1'b1;
   logic       step_en;
   logic [7:0] step_count;
   logic [2:0] state_dbg;

   int checks = 0;
   int failures = 0;

   step_controller #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_CYCLES   (R)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .step_mode  (step_mode),
      .key_n      (key_n),
      .step_en    (step_en),
      .step_count (step_count),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: delay line for the synchronizers, then counts of
   // consecutive pressed/released samples decide when presses are accepted.
   bit m_ms1, m_ms2, m_ks1, m_ks2;
   bit m_run, m_latched, m_pulse;
   int m_low, m_high, m_hold, m_cnt;

   task automatic model_reset();
      m_ms1 = 1; m_ms2 = 1; m_ks1 = 1; m_ks2 = 1;
      m_run = 0; m_latched = 0; m_pulse = 0;
      m_low = 0; m_high = 0; m_hold = 0; m_cnt = 0;
   endtask

   task automatic model_edge();
      bit s_mode, s_press;
      s_mode  = m_ms2;
      s_press = !m_ks2;
      m_ms2 = m_ms1; m_ms1 = step_mode;
      m_ks2 = m_ks1; m_ks1 = key_n;
      if (!s_mode) begin
         m_run = 1; m_latched = 0; m_pulse = 0;
         m_low = 0; m_high = 0; m_hold = 0;
      end else if (m_run) begin
         m_run = 0;                       // key ignored on the way out
      end else if (m_pulse) begin
         m_pulse = 0; m_latched = 1; m_hold = 0; m_high = 0;
      end else if (!m_latched) begin
         m_low = s_press ? m_low + 1 : 0;
         if (m_low == int'(D) + 1) begin
            m_pulse = 1; m_low = 0; m_cnt++;
         end
      end else if (!s_press) begin
         m_high++; m_hold = 0;
         if (m_high == int'(D) + 1) begin
            m_latched = 0; m_high = 0; m_low = 0;
         end
      end else if (m_high > 0) begin
         m_high = 0; m_hold = 0;          // bounce back to holding
      end else begin
         m_hold++;
         if (m_hold == int'(R)) begin
            m_pulse = 1; m_hold = 0; m_cnt++;
         end
      end
   endtask

   function automatic int exp_state();
      if (m_run)      return 0;
      if (m_pulse)    return 3;
      if (!m_latched) return (m_low == 0) ? 1 : 2;
      return (m_high == 0) ? 4 : 5;
   endfunction

   task automatic check_outputs();
      check_eq("step_en", 32'(step_en), 32'(m_run || m_pulse));
      check_eq("step_count", 32'(step_count), 32'(m_cnt % 256));
      check_eq("state_dbg", 32'(state_dbg), 32'(exp_state()));
   endtask

   // Called at a falling edge; drives inputs, advances one cycle, checks.
   task automatic tick(input logic mode_v, input logic key_v);
      step_mode = mode_v;
      key_n     = key_v;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset(input logic mode_v, input logic key_v);
      step_mode = mode_v;
      key_n     = key_v;
      #1 rst = 1'b0;
      #1;
      check_eq("rst_step_en", 32'(step_en), 32'd0);
      check_eq("rst_state", 32'(state_dbg), 32'd1);
      check_eq("rst_count", 32'(step_count), 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int n_pulse;
      int first;
      int pq[$];
      int exp_p[4];
      exp_p = '{7, 24, 41, 58};
      model_reset();

      // Free-run after reset: strobe from cycle 3 onward.
      do_reset(1'b0, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         tick(1'b0, 1'b1);
         check_eq("s1_en", 32'(step_en), 32'(i >= 3));
      end
      check_eq("s1_count", 32'(step_count), 32'd0);

      // Clean press of 10 cycles: one pulse at cycle 7.
      for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
      check_eq("s2_idle", 32'(state_dbg), 32'd1);
      n_pulse = 0; first = -1;
      for (int i = 1; i <= 20; i++) begin
         tick(1'b1, (i <= 10) ? 1'b0 : 1'b1);
         if (step_en) begin
            n_pulse++;
            if (first < 0) first = i;
         end
      end
      check_eq("s2_pulses", 32'(n_pulse), 32'd1);
      check_eq("s2_latency", 32'(first), 32'd7);
      check_eq("s2_count", 32'(step_count), 32'd1);

      // Bouncing key: never accepted.
      n_pulse = 0;
      for (int i = 0; i < 30; i++) begin
         tick(1'b1, (i >= 20 || ((i / 2) % 2) == 1) ? 1'b1 : 1'b0);
         if (step_en) n_pulse++;
      end
      check_eq("s3_pulses", 32'(n_pulse), 32'd0);
      check_eq("s3_idle", 32'(state_dbg), 32'd1);

      // Held 60 cycles: auto-repeat every REPEAT_CYCLES+1.
      for (int i = 1; i <= 72; i++) begin
         tick(1'b1, (i <= 60) ? 1'b0 : 1'b1);
         if (step_en) pq.push_back(i);
      end
      check_eq("s4_npulse", 32'(pq.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         check_eq("s4_pulse_at", (k < pq.size()) ? 32'(pq[k]) : 32'hFFFF_FFFF, 32'(exp_p[k]));
      end
      check_eq("s4_count", 32'(step_count), 32'd5);

      // 256 presses wrap the count; free-run wins over a held key.
      do_reset(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
      n_pulse = 0;
      for (int p = 0; p < 256; p++) begin
         for (int i = 0; i < 20; i++) begin
            tick(1'b1, (i < 10) ? 1'b0 : 1'b1);
            if (step_en) n_pulse++;
         end
      end
      check_eq("s5_npulse", 32'(n_pulse), 32'd256);
      check_eq("s5_wrap", 32'(step_count), 32'd0);
      for (int i = 0; i < 15; i++) tick(1'b1, 1'b0);
      check_eq("s5_held", 32'(state_dbg), 32'd4);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      check_eq("s5_sync_delay", 32'(state_dbg), 32'd4);
      tick(1'b0, 1'b0);
      check_eq("s5_run", 32'(state_dbg), 32'd0);
      check_eq("s5_run_en", 32'(step_en), 32'd1);

      // Reset mid-debounce discards the press.
      for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
      check_eq("s6_dbpress", 32'(state_dbg), 32'd2);
      do_reset(1'b1, 1'b0);
      for (int i = 1; i <= 7; i++) begin
         tick(1'b1, 1'b0);
         check_eq("s6_en", 32'(step_en), 32'(i == 7));
      end
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);

      // Random segments of key and mode levels.
      for (int s = 0; s < 60; s++) begin
         logic mv, kv;
         int len;
         mv  = ($urandom_range(0, 9) != 0);
         kv  = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 40);
         for (int i = 0; i < len; i++) tick(mv, kv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500_000, giving the stable-level cycles required to accept a key edge.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 25_000_000, giving the auto-repeat interval while the key stays held.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port step_mode, input, 1 bit: raw switch level; 1 = single-step, 0 = free-run.
REQ-006 SHALL have port key_n, input, 1 bit: raw pushbutton level; 0 = pressed.
REQ-007 SHALL have port step_en, output, 1 bit: advance strobe to the program counter and register file.
REQ-008 SHALL have port step_count, output, 8 bits: number of step_en pulses issued in single-step mode, modulo 256.
REQ-009 SHALL have port state_dbg, output, 3 bits: encoded current FSM state for the hex debug display.

Function
REQ-010 SHALL pass step_mode and key_n each through a 2-flop synchronizer; all logic SHALL use only the synchronized levels.
REQ-011 SHALL implement states RUN, IDLE, DB_PRESS, PULSE, HELD and DB_RELEASE.
REQ-012 In RUN, step_en SHALL be 1 every cycle; synchronized step_mode = 1 SHALL move RUN to IDLE on the next edge.
REQ-013 In IDLE, synchronized key = pressed SHALL move to DB_PRESS and clear the timer.
REQ-014 In DB_PRESS, key released before the timer reaches DEBOUNCE_CYCLES-1 SHALL return to IDLE; otherwise the FSM SHALL move to PULSE.
REQ-015 PULSE SHALL last exactly one cycle with step_en = 1, then move to HELD with the timer cleared.
REQ-016 In HELD, key released SHALL move to DB_RELEASE; a timer at REPEAT_CYCLES-1 with the key still pressed SHALL move to PULSE.
REQ-017 In DB_RELEASE, key pressed again before DEBOUNCE_CYCLES elapse SHALL return to HELD; otherwise the FSM SHALL move to IDLE.
REQ-018 step_en SHALL be 0 in every state except RUN and PULSE; it SHALL be a registered output.
REQ-019 Synchronized step_mode = 0 SHALL force RUN on the next edge from any state and SHALL override all key activity.
REQ-020 Latency from a stable raw press to step_en SHALL be 2 synchronizer cycles + DEBOUNCE_CYCLES + 1, fixed.
REQ-021 step_count SHALL increment by 1 on each PULSE cycle, wrap 255 -> 0, and hold in RUN.
REQ-022 The timer SHALL be sized by $clog2 of the larger parameter and SHALL never overflow.
REQ-023 state_dbg SHALL use RUN=0, IDLE=1, DB_PRESS=2, PULSE=3, HELD=4, DB_RELEASE=5.

Reset
REQ-024 rst low SHALL asynchronously force the following values: FSM = IDLE, step_en = 0, step_count = 0, timer = 0, synchronizers = {step_mode 1, key_n 1}.
REQ-025 Deassertion of rst SHALL take effect on the next clk edge; a mid-press reset SHALL discard the press and require a fresh debounce.
REQ-026 No step_en pulse SHALL be emitted in the first 2 cycles after reset release.

Structure
REQ-027 The state enum, the state_dbg encodings and the default parameter values SHALL live in shared package step_ctrl_pkg.
REQ-028 The debounce/repeat timer SHALL be one instance of the existing counter sub-module, cleared on every state entry.
REQ-029 The FSM next-state logic SHALL be a single combinational process; all outputs SHALL be registered.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16)
REQ-030 Scenario 1: reset, then step_mode=0 -> step_en=1 continuously from cycle 3 onward; step_count stays 0.
REQ-031 Scenario 2: step_mode=1, key_n held low 10 cycles, then released -> exactly one step_en pulse 7 cycles after the press edge; step_count=1.
REQ-032 Scenario 3: key_n bounces low/high every 2 cycles for 20 cycles, then goes high -> no step_en pulse; FSM ends in IDLE.
REQ-033 Scenario 4: key_n held low for 60 cycles -> pulses at cycle 7, then every 17 cycles (7, 24, 41, 58); step_count=4.
REQ-034 Scenario 5: 256 clean presses -> step_count wraps to 0; step_mode dropped during HELD -> RUN next cycle, with step_en=1.
REQ-035 Scenario 6: rst asserted low during DB_PRESS -> step_en=0 immediately, state_dbg=1, no pulse until a new full debounce completes.
